// File: rtl/cla_arb_pkg.sv
// Shared constants, types and the round-robin pick used by the cla32 arbiter.
package cla_arb_pkg;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;

    typedef logic [IDW-1:0]  req_id_t;
    typedef logic [NREQ-1:0] req_vec_t;

    // Search begins just past the last winner; IDW-bit arithmetic provides the wrap.
    function automatic req_vec_t rr_pick(input req_vec_t req, input req_id_t last);
        req_vec_t gnt;
        req_id_t  idx;
        logic     found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last + req_id_t'(k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic req_id_t oh_to_id(input req_vec_t oh);
        req_id_t id;
        id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                id = req_id_t'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups joined by a flattened group-carry network.
module cla32
    import cla_arb_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    localparam int GW = 4;
    localparam int NG = W / GW;

    logic [W-1:0]  w_g;
    logic [W-1:0]  w_p;
    logic [W-1:0]  w_c;
    logic [NG-1:0] w_gg;
    logic [NG-1:0] w_gp;
    logic [NG:0]   w_gc;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        int bs;
        for (int j = 0; j < NG; j++) begin
            bs = j * GW;
            w_gg[j] = w_g[bs+3]
                    | (w_p[bs+3] & w_g[bs+2])
                    | (w_p[bs+3] & w_p[bs+2] & w_g[bs+1])
                    | (w_p[bs+3] & w_p[bs+2] & w_p[bs+1] & w_g[bs]);
            w_gp[j] = &w_p[bs +: GW];
        end
    end

    // Each group carry is a sum of products over lower groups, not a chain through w_gc.
    always_comb begin
        logic t;
        logic pr;
        w_gc    = '0;
        w_gc[0] = ci;
        for (int j = 0; j < NG; j++) begin
            t = ci;
            for (int k = 0; k <= j; k++) begin
                t = t & w_gp[k];
            end
            for (int m = 0; m <= j; m++) begin
                pr = w_gg[m];
                for (int k = m + 1; k <= j; k++) begin
                    pr = pr & w_gp[k];
                end
                t = t | pr;
            end
            w_gc[j+1] = t;
        end
    end

    always_comb begin
        int   bs;
        logic c0;
        w_c = '0;
        for (int j = 0; j < NG; j++) begin
            bs = j * GW;
            c0 = w_gc[j];
            w_c[bs]   = c0;
            w_c[bs+1] = w_g[bs] | (w_p[bs] & c0);
            w_c[bs+2] = w_g[bs+1] | (w_p[bs+1] & w_g[bs]) | (w_p[bs+1] & w_p[bs] & c0);
            w_c[bs+3] = w_g[bs+2]
                      | (w_p[bs+2] & w_g[bs+1])
                      | (w_p[bs+2] & w_p[bs+1] & w_g[bs])
                      | (w_p[bs+2] & w_p[bs+1] & w_p[bs] & c0);
        end
    end

    assign s  = w_p ^ w_c;
    assign co = w_gc[NG];

endmodule

// File: rtl/cla32_arbiter.sv
// Four-way round-robin arbiter feeding a two-stage pipeline around one shared cla32 adder.
module cla32_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        a_in,
    input  logic [NREQ*W-1:0]        b_in,
    input  logic [NREQ-1:0]          ci_in,
    output logic [NREQ-1:0]          gnt,
    output logic [W-1:0]             s_out,
    output logic                     co_out,
    output logic [$clog2(NREQ)-1:0]  id_out,
    output logic                     valid_out,
    input  logic                     out_ready
);

    import cla_arb_pkg::*;

    logic         w_adv1;
    logic         w_adv2;
    logic         w_xfer;
    req_vec_t     w_pick;
    req_vec_t     w_gnt;
    req_id_t      w_gnt_id;
    logic [W-1:0] w_a_sel;
    logic [W-1:0] w_b_sel;
    logic         w_c_sel;
    logic [W-1:0] w_sum;
    logic         w_co;

    logic         r_v1;
    logic [W-1:0] r_a1;
    logic [W-1:0] r_b1;
    logic         r_c1;
    req_id_t      r_id1;
    logic         r_valid_out;
    logic [W-1:0] r_s_out;
    logic         r_co_out;
    req_id_t      r_id_out;
    req_id_t      r_last;

    assign w_adv2 = !r_valid_out || out_ready;
    assign w_adv1 = !r_v1 || w_adv2;

    // rr_pick only returns requesting bits, so any grant is a transfer.
    assign w_pick   = rr_pick(req, r_last);
    assign w_gnt    = (reset_n && w_adv1) ? w_pick : '0;
    assign w_xfer   = |w_gnt;
    assign w_gnt_id = oh_to_id(w_gnt);

    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        w_c_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_a_sel = a_in[i*W +: W];
                w_b_sel = b_in[i*W +: W];
                w_c_sel = ci_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1   <= 1'b0;
            r_a1   <= '0;
            r_b1   <= '0;
            r_c1   <= 1'b0;
            r_id1  <= '0;
            r_last <= req_id_t'(NREQ - 1);
        end else begin
            if (w_adv1) begin
                r_v1 <= w_xfer;
                if (w_xfer) begin
                    r_a1  <= w_a_sel;
                    r_b1  <= w_b_sel;
                    r_c1  <= w_c_sel;
                    r_id1 <= w_gnt_id;
                end
            end
            if (w_xfer) begin
                r_last <= w_gnt_id;
            end
        end
    end

    cla32 u_cla32 (
        .a  (r_a1),
        .b  (r_b1),
        .ci (r_c1),
        .s  (w_sum),
        .co (w_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_out <= 1'b0;
            r_s_out     <= '0;
            r_co_out    <= 1'b0;
            r_id_out    <= '0;
        end else if (w_adv2) begin
            r_valid_out <= r_v1;
            if (r_v1) begin
                r_s_out  <= w_sum;
                r_co_out <= w_co;
                r_id_out <= r_id1;
            end
        end
    end

    assign gnt       = w_gnt;
    assign s_out     = r_s_out;
    assign co_out    = r_co_out;
    assign id_out    = r_id_out;
    assign valid_out = r_valid_out;

endmodule

// File: tb/tb_cla32_arbiter.sv
// Self-checking bench for cla32_arbiter: directed vectors, corner sequences and a random run.
module tb_cla32_arbiter;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req;
    logic [127:0] a_in;
    logic [127:0] b_in;
    logic [3:0]   ci_in;
    logic [3:0]   gnt;
    logic [31:0]  s_out;
    logic         co_out;
    logic [1:0]   id_out;
    logic         valid_out;
    logic         out_ready;

    cla32_arbiter #(
        .NREQ (4),
        .W    (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .ci_in     (ci_in),
        .gnt       (gnt),
        .s_out     (s_out),
        .co_out    (co_out),
        .id_out    (id_out),
        .valid_out (valid_out),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: in-flight results in order; an item is visible once one edge has passed.
    typedef struct {
        logic [31:0] s;
        logic        co;
        logic [1:0]  id;
        int          age;
    } item_t;

    item_t q[$];
    int    m_last;
    int    checks;
    int    failures;

    logic [3:0] o_gnt;
    logic       o_valid;
    logic [1:0] o_id;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] es;
        logic        eco;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic ci);
        a_in[id*32 +: 32] = a;
        b_in[id*32 +: 32] = b;
        ci_in[id]         = ci;
    endtask

    function automatic logic [3:0] exp_gnt();
        logic [3:0] g;
        int         idx;
        g = '0;
        if (reset_n !== 1'b1) return g;
        if (q.size() == 2 && !out_ready) return g;
        for (int k = 1; k <= 4; k++) begin
            idx = (m_last + k) % 4;
            if (req[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic cycle();
        logic [3:0] eg;
        logic       ev;
        logic       pop;
        int         idx;
        item_t      it;
        @(negedge clk);
        eg = exp_gnt();
        ev = (q.size() > 0) && (q[0].age >= 1);
        chk("gnt", {60'd0, gnt}, {60'd0, eg});
        chk("valid_out", {63'd0, valid_out}, {63'd0, ev});
        if (ev) begin
            chk("s_out", {32'd0, s_out}, {32'd0, q[0].s});
            chk("co_out", {63'd0, co_out}, {63'd0, q[0].co});
            chk("id_out", {62'd0, id_out}, {62'd0, q[0].id});
        end
        o_gnt   = gnt;
        o_valid = valid_out;
        o_id    = id_out;
        pop     = ev && out_ready;
        idx     = 0;
        it      = '{s: 32'd0, co: 1'b0, id: 2'd0, age: 0};
        if (eg != 4'd0) begin
            for (int i = 0; i < 4; i++) if (eg[i]) idx = i;
            {it.co, it.s} = {1'b0, a_in[idx*32 +: 32]} + {1'b0, b_in[idx*32 +: 32]}
                          + {32'd0, ci_in[idx]};
            it.id = 2'(idx);
        end
        @(posedge clk);
        if (pop) void'(q.pop_front());
        for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
        if (eg != 4'd0) begin
            q.push_back(it);
            m_last = idx;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req     = 4'hF;
        reset_n = 1'b0;
        #1;
        chk("rst_valid", {63'd0, valid_out}, 64'd0);
        chk("rst_s", {32'd0, s_out}, 64'd0);
        chk("rst_co", {63'd0, co_out}, 64'd0);
        chk("rst_id", {62'd0, id_out}, 64'd0);
        chk("rst_gnt", {60'd0, gnt}, 64'd0);
        req = 4'h0;
        q.delete();
        m_last = 3;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] rr_exp[5];
        logic [3:0] one_hot;
        logic [1:0] ids[$];
        logic [31:0] s_snap;
        int          ng;

        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        ci_in     = '0;
        out_ready = 1'b1;
        o_gnt     = '0;
        m_last    = 3;

        vt[0] = '{id: 0, a: 32'hFFFFFFFF, b: 32'h00000001, ci: 1'b0, es: 32'h00000000, eco: 1'b1};
        vt[1] = '{id: 2, a: 32'h7FFFFFFF, b: 32'h00000000, ci: 1'b1, es: 32'h80000000, eco: 1'b0};
        vt[2] = '{id: 1, a: 32'h12345678, b: 32'h87654321, ci: 1'b0, es: 32'h99999999, eco: 1'b0};
        vt[3] = '{id: 3, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, ci: 1'b1, es: 32'hFFFFFFFF, eco: 1'b1};
        vt[4] = '{id: 0, a: 32'h00000000, b: 32'h00000000, ci: 1'b0, es: 32'h00000000, eco: 1'b0};
        vt[5] = '{id: 1, a: 32'h80000000, b: 32'h80000000, ci: 1'b0, es: 32'h00000000, eco: 1'b1};
        vt[6] = '{id: 2, a: 32'hAAAAAAAA, b: 32'h55555555, ci: 1'b1, es: 32'h00000000, eco: 1'b1};

        do_reset();

        // Table: one requester at a time, result two edges after the grant.
        foreach (vt[n]) begin
            set_op(vt[n].id, vt[n].a, vt[n].b, vt[n].ci);
            one_hot = 4'b0001 << vt[n].id;
            req = one_hot;
            cycle();
            chk("tbl_gnt", {60'd0, o_gnt}, {60'd0, one_hot});
            req = 4'h0;
            cycle();
            chk("tbl_valid", {63'd0, valid_out}, 64'd1);
            chk("tbl_s", {32'd0, s_out}, {32'd0, vt[n].es});
            chk("tbl_co", {63'd0, co_out}, {63'd0, vt[n].eco});
            chk("tbl_id", {62'd0, id_out}, vt[n].id);
            cycle();
            cycle();
        end

        // Round robin with all four requesting.
        do_reset();
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;
        for (int i = 0; i < 4; i++) set_op(i, 32'h1000 * (i + 1), 32'(i), 1'b0);
        req = 4'hF;
        ids.delete();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_gnt", {60'd0, o_gnt}, {60'd0, rr_exp[k]});
            if (o_valid) ids.push_back(o_id);
        end
        req = 4'h0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (o_valid) ids.push_back(o_id);
        end
        chk("rr_count", ids.size(), 5);
        for (int k = 0; k < ids.size() && k < 5; k++) begin
            chk("rr_id", {62'd0, ids[k]}, k % 4);
        end

        // Backpressure: only two transfers fit while the consumer stalls.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_op(i, 32'h100 + i, 32'h10, 1'b1);
        req = 4'b0111;
        ng  = 0;
        s_snap = '0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (o_gnt != 4'd0) begin
                ng++;
                req = req & ~o_gnt;
            end
            if (k == 2) s_snap = s_out;
        end
        chk("bp_grants", ng, 2);
        chk("bp_gnt_idle", {60'd0, gnt}, 64'd0);
        chk("bp_s_stable", {32'd0, s_out}, {32'd0, s_snap});
        out_ready = 1'b1;
        ids.delete();
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (o_gnt != 4'd0) req = req & ~o_gnt;
            if (o_valid) ids.push_back(o_id);
        end
        chk("bp_drained", ids.size(), 3);
        for (int k = 0; k < ids.size() && k < 3; k++) begin
            chk("bp_order", {62'd0, ids[k]}, k);
        end

        // Reset while both stages are full.
        do_reset();
        out_ready = 1'b0;
        set_op(0, 32'd5, 32'd6, 1'b0);
        set_op(1, 32'd5, 32'd6, 1'b0);
        req = 4'b0011;
        cycle();
        req = req & ~o_gnt;
        cycle();
        chk("mid_valid_before", {63'd0, valid_out}, 64'd1);
        chk("mid_s_before", {32'd0, s_out}, 64'd11);
        req = 4'hF;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, valid_out}, 64'd0);
        chk("mid_rst_s", {32'd0, s_out}, 64'd0);
        chk("mid_rst_co", {63'd0, co_out}, 64'd0);
        chk("mid_rst_gnt", {60'd0, gnt}, 64'd0);
        q.delete();
        m_last = 3;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("mid_first_gnt", {60'd0, o_gnt}, 64'd1);
        req = 4'h0;
        for (int k = 0; k < 3; k++) cycle();

        // Withdrawal: requester 1 drops before being sampled, so 2 wins.
        do_reset();
        set_op(0, 32'd1, 32'd2, 1'b0);
        req = 4'b0001;
        cycle();
        req = 4'b0110;
        #1;
        chk("wd_pre_gnt", {60'd0, gnt}, 64'h2);
        req = 4'b0100;
        cycle();
        chk("wd_gnt", {60'd0, o_gnt}, 64'h4);
        req = 4'h0;
        for (int k = 0; k < 3; k++) cycle();

        // Random traffic with withdrawals and random backpressure.
        do_reset();
        o_gnt = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && o_gnt[i]) req[i] = 1'b0;
                if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1;
                        set_op(i, ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
                               $urandom, 1'($urandom_range(0, 1)));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req       = 4'h0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        chk("final_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla32_arbiter.md
# cla32_arbiter

Round-robin arbiter and two-stage pipeline that shares a single `cla32` adder among four requesters. Each requester presents operands and carry-in under a req/gnt handshake. The block registers the winning operands, computes the sum through one `cla32` instance, and returns a registered result tagged with the requester ID under a valid/ready handshake. It sits between the integer-op clients and the adder datapath, so the design needs only one 32-bit adder.

## Interface
Parameters:
- `NREQ`, 4: number of requesters. Fixed at 4; the ID width derives from it.
- `W`, 32: operand width. Fixed by `cla32`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request per requester. Held with operands until granted.
- `a_in`  in  128  operand A; requester i on bits [32i+31:32i].
- `b_in`  in  128  operand B; same packing as `a_in`.
- `ci_in`  in  4  carry-in per requester.
- `gnt`  out  4  one-hot grant, combinational. Transfer occurs when `req[i] && gnt[i]` at a rising edge.
- `s_out`  out  32  registered sum.
- `co_out`  out  1  registered carry-out.
- `id_out`  out  2  requester index of the current result.
- `valid_out`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result when `valid_out && out_ready`.

## Operation
- **Stage 1 (operand register):**
  - Registers: `v1`, `a1[31:0]`, `b1[31:0]`, `c1`, `id1`.
  - Loads the winning requester's operands on a grant.
  - Clears `v1` when its contents advance and there is no new grant.
- **Stage 2 (result register):**
  - Registers: `valid_out`, `s_out`, `co_out`, `id_out`.
  - Loads from `cla32(a1, b1, c1)` when stage 1 advances.
- **Advance conditions:**
  - `adv2 = !valid_out || out_ready`
  - `adv1 = !v1 || adv2`
  - `gnt` is nonzero only when `adv1` is high and at least one `req` is high.
- **Round-robin pointer:**
  - `last[1:0]` holds the last granted index.
  - The search starts at `last+1` and wraps modulo 4. The first set `req` in that order wins.
  - `last` updates only on a transfer.
- **Arithmetic:**
  - `{co_out, s_out} = a + b + ci`, modulo 2^33.
  - No saturation and no overflow flag.
- **Stall:** when `valid_out && !out_ready`:
  - Stage 2 holds its contents.
  - Stage 1 holds if `v1` is set.
  - `gnt` is 0 while stage 1 is full.
  - Requesters keep `req` asserted; no request is dropped.
- **Request withdrawal:** a requester that deasserts `req` before being granted is simply skipped. This is legal.
- **Reset values (all asynchronous on `reset_n` low):**
  - `v1 = 0`, `valid_out = 0`, `s_out = 0`, `co_out = 0`, `id_out = 0`.
  - `last = 3`, so requester 0 has first priority.
  - `gnt = 0` while `reset_n` is low.
- **Reset mid-operation:** all in-flight results are discarded. There is no replay, and requesters re-present after reset.

## Timing
- Latency: a transfer at edge T gives `valid_out = 1` from T+1 to T+2, with the result in stage 2 after edge T+1. That is 2 edges from grant to result.
- Throughput: one add per cycle when `out_ready` is held high.
- `gnt` is combinational from `req`, `v1`, `valid_out`, `out_ready` and `last`. No combinational path exists from `a_in`/`b_in` to any output.
- The `cla32` critical path lies entirely between the stage-1 and stage-2 registers.
- Simultaneous events in one cycle (consumer accepting, stage 1 advancing, new grant) all complete in that same cycle.

## Structure
- Package `cla_arb_pkg`:
  - `localparam NREQ = 4`, `W = 32`, `IDW = 2`.
  - `typedef logic [IDW-1:0] req_id_t`.
  - Function `rr_pick(req, last)`, which returns a one-hot grant.
- Sub-module: one `cla32` instance (a, b, ci, s, co) as the sole adder.
- The arbiter and pipeline registers live in `cla32_arbiter`.

## Test plan
- **Single add with carry-out:** req[0], a=0xFFFFFFFF, b=0x00000001, ci=0, out_ready=1. Expect gnt=0001, then 2 edges later s_out=0x00000000, co_out=1, id_out=0, valid_out high for 1 cycle.
- **Carry-in:** req[2], a=0x7FFFFFFF, b=0, ci=1. Expect s_out=0x80000000, co_out=0, id_out=2.
- **Round robin:** all four req held high for 5 transfers. Expect grant order 0,1,2,3,0, results back-to-back, and id_out sequence 0,1,2,3,0.
- **Backpressure:** out_ready=0 while 3 requests are pending. Expect exactly 2 grants (stage 1 and stage 2 full), then gnt=0 and outputs stable. Raise out_ready: remaining results drain in order with no loss or duplication.
- **Reset mid-operation:** pull reset_n low while valid_out=1 and v1=1. Expect immediately valid_out=0, s_out=0, co_out=0, gnt=0. After release with req=1111, the first grant goes to 0.
- **Withdrawal:** last=0, req=0110; req[1] drops before sampling. Expect the grant to go to 2.
